// File: rtl/xrek_step_dispatcher.sv
// Walks an orchestrated step list and dispatches each step to one agent over valid/ready.
// Tracks cost against a budget, retries timed-out steps and reports one workflow status.
module xrek_step_dispatcher #(
  parameter int unsigned STEP_W         = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              orch_done,
  input  logic [7:0]        orch_step_count,
  input  logic [31:0]       orch_agent,
  input  logic [31:0]       max_cost,
  output logic [4:0]        step_idx,
  input  logic [STEP_W-1:0] step_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [31:0]       disp_agent,
  output logic [STEP_W-1:0] disp_step,
  output logic [4:0]        disp_idx,
  input  logic              resp_valid,
  input  logic              resp_ok,
  input  logic [31:0]       resp_cost,
  output logic              wf_busy,
  output logic              wf_done,
  output logic [1:0]        wf_status,
  output logic [5:0]        steps_completed,
  output logic [31:0]       total_cost
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_STEPERR = 2'd1;
  localparam logic [1:0] ST_BUDGET  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DISPATCH,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t            r_state;
  logic              r_orch_d;
  logic [5:0]        r_n;
  logic [31:0]       r_max_cost;
  logic [TO_W-1:0]   r_to_cnt;
  logic [RT_W-1:0]   r_retry;

  logic              w_start;
  logic [5:0]        w_n;
  logic              w_last;
  logic [32:0]       w_sum;
  logic [31:0]       w_cost_sat;
  logic [TO_W-1:0]   w_to_next;
  logic              w_to_hit;

  // Start detection, clamped step count and saturating cost sum
  always_comb begin
    w_start    = orch_done & ~r_orch_d;
    w_n        = (orch_step_count > 8'd32) ? 6'd32 : orch_step_count[5:0];
    w_last     = ({1'b0, step_idx} == (r_n - 6'd1));
    w_sum      = {1'b0, total_cost} + {1'b0, resp_cost};
    w_cost_sat = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
    w_to_next  = r_to_cnt + TO_W'(1);
    w_to_hit   = (w_to_next >= TO_W'(TIMEOUT_CYCLES));
  end

  // Workflow FSM; FINISH is entered with wf_done already asserted so it pulses for that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_orch_d        <= 1'b0;
      r_n             <= '0;
      r_max_cost      <= '0;
      r_to_cnt        <= '0;
      r_retry         <= '0;
      step_idx        <= '0;
      disp_valid      <= 1'b0;
      disp_agent      <= '0;
      disp_step       <= '0;
      disp_idx        <= '0;
      wf_busy         <= 1'b0;
      wf_done         <= 1'b0;
      wf_status       <= ST_OK;
      steps_completed <= '0;
      total_cost      <= '0;
    end else begin
      r_orch_d <= orch_done;
      wf_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            disp_agent      <= orch_agent;
            r_max_cost      <= max_cost;
            r_n             <= w_n;
            total_cost      <= '0;
            steps_completed <= '0;
            step_idx        <= '0;
            r_retry         <= '0;
            wf_status       <= ST_OK;
            if (w_n == 6'd0) begin
              r_state <= S_FINISH;
              wf_done <= 1'b1;
              wf_busy <= 1'b0;
            end else begin
              r_state <= S_FETCH;
              wf_busy <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          disp_step  <= step_data;
          disp_idx   <= step_idx;
          disp_valid <= 1'b1;
          r_state    <= S_DISPATCH;
        end
        S_DISPATCH: begin
          if (disp_ready) begin
            disp_valid <= 1'b0;
            r_to_cnt   <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_to_cnt <= w_to_next;
          if (resp_valid) begin
            total_cost <= w_cost_sat;
            if (!resp_ok) begin
              wf_status <= ST_STEPERR;
              r_state   <= S_FINISH;
              wf_done   <= 1'b1;
              wf_busy   <= 1'b0;
            end else begin
              steps_completed <= steps_completed + 6'd1;
              if (w_cost_sat > r_max_cost) begin
                wf_status <= ST_BUDGET;
                r_state   <= S_FINISH;
                wf_done   <= 1'b1;
                wf_busy   <= 1'b0;
              end else if (w_last) begin
                wf_status <= ST_OK;
                r_state   <= S_FINISH;
                wf_done   <= 1'b1;
                wf_busy   <= 1'b0;
              end else begin
                step_idx <= step_idx + 5'd1;
                r_retry  <= '0;
                r_state  <= S_FETCH;
              end
            end
          end else if (w_to_hit) begin
            if (r_retry < RT_W'(MAX_RETRY)) begin
              r_retry    <= r_retry + RT_W'(1);
              disp_valid <= 1'b1;
              r_state    <= S_DISPATCH;
            end else begin
              wf_status <= ST_TIMEOUT;
              r_state   <= S_FINISH;
              wf_done   <= 1'b1;
              wf_busy   <= 1'b0;
            end
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
